inst_fetcher: RTL and testbench

INST_FETCHER -- requirements
Module: inst_fetcher

---
 rtl/inst_fetcher.sv | 141 ++++++++++++++
 tb/tb_inst_fetcher.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetcher: IDLE/FETCH cache handshake feeding a small decode queue.
// Define IFETCH_JAL_PREDICT_EN to redirect fetch on JAL and mark entries as predicted.
module inst_fetcher #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic [31:0] rob_new_pc,
    output logic [31:0] pc,
    output logic        start_fetch,
    input  logic        fetch_ready,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_pred_jump,
    input  logic        dec_ready
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_q_inst [QUEUE_DEPTH];
    logic [31:0]   r_q_pc   [QUEUE_DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_room;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_next_pc;

    assign w_room  = (r_count < CW'(QUEUE_DEPTH));
    assign w_flush = rdy_in & rob_clear_up;
    assign w_push  = rdy_in & ~rob_clear_up & (r_state == FETCH) & fetch_ready;
    assign w_pop   = rdy_in & ~rob_clear_up & dec_valid & dec_ready;

    assign pc          = r_pc;
    assign start_fetch = (r_state == FETCH);
    assign dec_valid   = (r_count != '0);
    assign dec_inst    = dec_valid ? r_q_inst[r_head] : 32'h0;
    assign dec_pc      = dec_valid ? r_q_pc[r_head] : 32'h0;

`ifdef IFETCH_JAL_PREDICT_EN
    logic          r_q_pred [QUEUE_DEPTH];
    logic          w_is_jal;
    logic [31:0]   w_jimm;

    assign w_is_jal  = (inst[6:0] == 7'b1101111);
    assign w_jimm    = {{11{inst[31]}}, inst[31], inst[19:12],
                        inst[20], inst[30:21], 1'b0};
    assign w_next_pc = w_is_jal ? (r_pc + w_jimm) : (r_pc + 32'd4);

    assign dec_pred_jump = dec_valid & r_q_pred[r_head];

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_q_pred[r_tail] <= w_is_jal;
        end
    end
`else
    assign w_next_pc     = r_pc + 32'd4;
    assign dec_pred_jump = 1'b0;
`endif

    // A flush always wins, so the cache sees one idle cycle before the next request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_room) w_state_nxt = FETCH;
            FETCH: if (fetch_ready) w_state_nxt = IDLE;
        endcase
        if (rob_clear_up) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pc <= RESET_PC;
        end else if (w_flush) begin
            r_pc <= rob_new_pc;
        end else if (w_push) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload needs no reset: outputs are masked by dec_valid.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_q_inst[r_tail] <= inst;
            r_q_pc[r_tail]   <= inst_addr;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher with a fixed-latency cache model.
// Expectations follow IFETCH_JAL_PREDICT_EN when it is defined for the build.
module tb_inst_fetcher;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [31:0] npc;
    logic        fr;
    logic [31:0] inst;
    logic [31:0] iaddr;
    logic        dr;
    logic [31:0] pc;
    logic        sf;
    logic        dv;
    logic [31:0] dinst;
    logic [31:0] dpc;
    logic        dpred;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        sb[$];
    int          n_vec;
    int          n_err;
    int          n_push;
    int          cyc_no;
    int          last_push_cyc;
    int          gap;
    int          cnt;
    int          p0;
    bit          toggle;
    bit          deq_en;
    bit          pop_on_ready;
    bit          flush_on_ready;
    bit          did_flush;
    logic [31:0] flush_pc;
    logic [31:0] jal_addr;
    logic [31:0] m_pc;

    inst_fetcher #(
        .QUEUE_DEPTH(4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .rob_clear_up (clr),
        .rob_new_pc   (npc),
        .pc           (pc),
        .start_fetch  (sf),
        .fetch_ready  (fr),
        .inst         (inst),
        .inst_addr    (iaddr),
        .dec_valid    (dv),
        .dec_inst     (dinst),
        .dec_pc       (dpc),
        .dec_pred_jump(dpred),
        .dec_ready    (dr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == jal_addr) return 32'h0100006F;
        return {a[11:0], 20'h00013};
    endfunction

    function automatic logic [31:0] exp_next(input logic [31:0] a,
                                             input logic [31:0] w,
                                             output logic p);
        p = 1'b0;
`ifdef IFETCH_JAL_PREDICT_EN
        if (w[6:0] == 7'h6F) begin
            p = 1'b1;
            return a + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        end
`endif
        return a + 32'd4;
    endfunction

    task automatic cyc();
        logic hit;
        logic push;
        logic pop;
        logic sf0;
        logic clr0;
        logic p;
        logic [31:0] nx;
        ent_t e;
        hit    = sf && (cnt == LAT - 1);
        fr     = hit && (rdy || toggle);
        toggle = !toggle;
        inst   = mem(pc);
        iaddr  = pc;
        if (flush_on_ready && fr) begin
            clr            = 1'b1;
            npc            = flush_pc;
            flush_on_ready = 1'b0;
            did_flush      = 1'b1;
        end
        dr = deq_en || (pop_on_ready && fr);
        #1;
        sf0  = sf;
        clr0 = rdy && clr;
        push = rdy && !clr && sf && fr;
        pop  = rdy && !clr && dv && dr;
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dec_inst", dinst, e.inst);
                chk("dec_pc", dpc, e.pc);
                chk("dec_pred", {31'd0, dpred}, {31'd0, e.pred});
            end
        end
        if (push) begin
            chk("fetch_pc", pc, m_pc);
            nx = exp_next(m_pc, inst, p);
            sb.push_back('{inst, m_pc, p});
            m_pc = nx;
            n_push++;
            gap = cyc_no - last_push_cyc;
            last_push_cyc = cyc_no;
        end
        if (clr0) begin
            sb.delete();
            m_pc = npc;
        end
        @(posedge clk);
        #1;
        cyc_no++;
        clr = 1'b0;
        if (rdy) cnt = (push || clr0 || !sf0) ? 0 : cnt + 1;
        chk("dec_valid", {31'd0, dv}, {31'd0, sb.size() != 0});
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_push = 0; cyc_no = 0;
        last_push_cyc = 0; gap = 0; cnt = 0; toggle = 1'b0;
        deq_en = 1'b0; pop_on_ready = 1'b0; flush_on_ready = 1'b0;
        did_flush = 1'b0; flush_pc = 32'h0; jal_addr = 32'hFFFF_FFFF;
        m_pc = 32'h0;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; npc = 32'h0;
        fr = 1'b0; inst = 32'h0; iaddr = 32'h0; dr = 1'b0;

        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_sf", {31'd0, sf}, 32'd0);
        chk("rst_dv", {31'd0, dv}, 32'd0);
        chk("rst_dinst", dinst, 32'h0);
        chk("rst_dpc", dpc, 32'h0);
        chk("rst_dpred", {31'd0, dpred}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        chk("first_sf", {31'd0, sf}, 32'd1);

        // fill with decoder stalled
        repeat (40) cyc();
        chk("fill_count", n_push, 4);
        chk("fill_sf", {31'd0, sf}, 32'd0);
        chk("fill_pc", pc, 32'h10);
        chk("head_pc", dpc, 32'h0);
        chk("head_inst", dinst, 32'h13);

        // single pop reopens fetch
        deq_en = 1'b1;
        cyc();
        deq_en = 1'b0;
        cyc();
        chk("reopen_sf", {31'd0, sf}, 32'd1);

        // push and pop in the same cycle at count 3
        pop_on_ready = 1'b1;
        p0 = n_push;
        for (int i = 0; i < 20 && n_push == p0; i++) cyc();
        pop_on_ready = 1'b0;
        chk("swap_push", n_push, p0 + 1);
        p0 = n_push;
        repeat (20) cyc();
        chk("swap_refill", n_push - p0, 1);
        chk("swap_sf", {31'd0, sf}, 32'd0);

        // drain and stream
        deq_en = 1'b1;
        repeat (40) cyc();
        chk("stream_gap", gap, LAT + 1);

        // flush coinciding with fetch_ready
        flush_pc = 32'h1000;
        flush_on_ready = 1'b1;
        for (int i = 0; i < 20 && !did_flush; i++) cyc();
        chk("flush_seen", {31'd0, did_flush}, 32'd1);
        chk("flush_dv", {31'd0, dv}, 32'd0);
        chk("flush_pc", pc, 32'h1000);
        chk("flush_sf0", {31'd0, sf}, 32'd0);
        cyc();
        chk("flush_sf1", {31'd0, sf}, 32'd1);
        chk("flush_pc1", pc, 32'h1000);
        repeat (6) cyc();

        // JAL at pc 8
        deq_en = 1'b0;
        jal_addr = 32'h8;
        clr = 1'b1;
        npc = 32'h8;
        cyc();
        p0 = n_push;
        for (int i = 0; i < 20 && n_push == p0; i++) cyc();
        chk("jal_push", n_push, p0 + 1);
        chk("jal_dpc", dpc, 32'h8);
        chk("jal_dinst", dinst, 32'h0100006F);
`ifdef IFETCH_JAL_PREDICT_EN
        chk("jal_next_pc", pc, 32'h18);
        chk("jal_pred", {31'd0, dpred}, 32'd1);
`else
        chk("jal_next_pc", pc, 32'hC);
        chk("jal_pred", {31'd0, dpred}, 32'd0);
`endif

        // stall with fetch_ready pulsing
        for (int i = 0; i < 20 && !(sf && cnt == LAT - 1); i++) cyc();
        chk("stall_arm", {31'd0, sf}, 32'd1);
        rdy = 1'b0;
        p0 = n_push;
        repeat (3) begin
            cyc();
            chk("frz_pc", pc, m_pc);
            chk("frz_sf", {31'd0, sf}, 32'd1);
        end
        chk("frz_nopush", n_push, p0);
        rdy = 1'b1;
        cyc();
        chk("resume_push", n_push, p0 + 1);

        // asynchronous reset mid-fetch
        for (int i = 0; i < 20 && !sf; i++) cyc();
        chk("arst_arm", {31'd0, sf}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_sf", {31'd0, sf}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_dv", {31'd0, dv}, 32'd0);
        chk("arst_dinst", dinst, 32'h0);
        chk("arst_dpc", dpc, 32'h0);
        chk("arst_dpred", {31'd0, dpred}, 32'd0);
        sb.delete();
        m_pc = 32'h0;
        cnt = 0;
        rst = 1'b0;
        cyc();
        chk("arst_restart", {31'd0, sf}, 32'd1);
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
